reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter: X, 32, data MSB index; the data width SHALL be X+1 bits.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: req  input  4  per-requester request, level, held until granted.
REQ-005 Port: req_data  input  4*(X+1)  packed payloads; requester i occupies bits [i*(X+1) +: X+1].
REQ-006 Port: gnt  output  4  one-hot, one-cycle pulse marking the requester whose data was captured that edge.
REQ-007 Port: out_data  output  X+1  contents of the shared holding register.
REQ-008 Port: out_src  output  2  index of the requester that owns out_data.
REQ-009 Port: out_valid  output  1  the holding register contains unconsumed data.
REQ-010 Port: out_ready  input  1  consumer accepts out_data when out_valid && out_ready.

Function
REQ-011 The block SHALL share one (X+1)-bit holding register among 4 requesters using a two-state FSM: EMPTY and FULL.
REQ-012 In EMPTY with any req bit set, the block SHALL capture the winner's payload, set out_src, pulse gnt[winner] in the same cycle, and enter FULL next edge.
REQ-013 In EMPTY with req==0, the block SHALL remain in EMPTY with gnt==0.
REQ-014 The winner SHALL be the first set req bit, searching circularly from index ptr; ptr SHALL become (winner+1) mod 4 on each grant, with 3 wrapping to 0.
REQ-015 out_valid SHALL be 1 exactly when the state is FULL.
REQ-016 In FULL without out_ready, out_data, out_src, and ptr SHALL hold, and gnt SHALL be 0.
REQ-017 In FULL with out_ready, the consumer handshake SHALL complete and the next state SHALL be set per REQ-024/REQ-025.
REQ-018 Capture latency SHALL be 1 cycle: payload sampled at edge N SHALL appear on out_data after edge N.
REQ-019 gnt SHALL be combinational from state, req, ptr, and out_ready, and SHALL never have more than one bit set.
REQ-020 A requester that drops req before it is granted SHALL not be granted.

Reset
REQ-021 With rst_n==0 at a rising edge, the block SHALL set state=EMPTY, ptr=0, out_data=0, out_src=0.
REQ-022 During reset, gnt SHALL be 0 and out_valid SHALL be 0.
REQ-023 Reset while FULL SHALL discard the held word without any handshake.

Configuration
REQ-024 With macro REG_ARBITER_BACK2BACK_EN defined, FULL with out_ready and any req set SHALL capture the next winner in the same cycle, pulse gnt, and stay FULL (no bubble).
REQ-025 Without REG_ARBITER_BACK2BACK_EN, FULL with out_ready SHALL always go to EMPTY with gnt==0, inserting one bubble cycle between consecutive words.

Structure
REQ-026 A shared package reg_arbiter_pkg SHALL hold N_REQ=4, SRC_W=2, and the state enumeration {EMPTY, FULL}.
REQ-027 The circular priority pick SHALL be a combinational sub-module rr_pick with inputs req[3:0] and ptr[1:0] and outputs winner[1:0] and any.
REQ-028 The holding register SHALL be implemented in the top level, not in rr_pick.

Verification
REQ-029 Reset check: rst_n=0 for 2 cycles with req=4'hF -> gnt=0, out_valid=0, out_data=0, out_src=0.
REQ-030 Single requester: req=4'b0100, data2=33'h1_DEADBEEF -> gnt=4'b0100 for one cycle; next cycle out_valid=1, out_data=33'h1_DEADBEEF, out_src=2.
REQ-031 Fairness: req=4'hF held, out_ready=1 -> grant order 0,1,2,3,0 (gaps between grants depend on REQ-024/REQ-025).
REQ-032 Backpressure: FULL, out_ready=0 for 5 cycles with req=4'b0010 -> out_data stable, gnt=0 for all 5 cycles; out_ready=1 -> requester 1 granted per REQ-024/REQ-025.
REQ-033 Wrap: ptr=3 (last grant to 2), req=4'b1001 -> requester 3 granted, then requester 0.
REQ-034 Reset mid-operation: FULL with out_src=1, rst_n=0 for one edge -> out_valid=0 and ptr=0; next grant with req=4'b0011 goes to requester 0.

Source files
------------

// File: rtl/reg_arbiter_pkg.sv
// Shared definitions for the reg_arbiter slice: requester count, index width,
// holding-register state encoding and a one-hot helper.
package reg_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SRC_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SRC_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_arbiter_rr_pick.sv
// Circular priority pick: first set request bit at or after ptr, wrapping
// from the highest index back to 0.
module rr_pick
    import reg_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] winner,
    output logic             any
);

    logic [SRC_W-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr + SRC_W'(i);
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// Four requesters share one holding register behind an EMPTY/FULL FSM.
// Define REG_ARBITER_BACK2BACK_EN to refill on the consuming cycle (no bubble).
module reg_arbiter
    import reg_arbiter_pkg::*;
#(
    parameter int X = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*(X+1)-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    output logic [X:0]             out_data,
    output logic [SRC_W-1:0]       out_src,
    output logic                   out_valid,
    input  logic                   out_ready
);

    state_t           state;
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] winner;
    logic             any;
    logic             take;
    logic [X:0]       pick_data;

    rr_pick u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    assign pick_data = req_data[32'(winner) * (X+1) +: (X+1)];

    // take marks a capture edge; in FULL it already implies the word is consumed
    always_comb begin
        take = 1'b0;
        case (state)
            EMPTY: take = rst_n && any;
            FULL: begin
`ifdef REG_ARBITER_BACK2BACK_EN
                take = rst_n && any && out_ready;
`else
                take = 1'b0;
`endif
            end
            default: take = 1'b0;
        endcase
    end

    assign gnt       = take ? onehot(winner) : '0;
    assign out_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ptr      <= '0;
            out_data <= '0;
            out_src  <= '0;
        end else if (take) begin
            out_data <= pick_data;
            out_src  <= winner;
            ptr      <= winner + 1'b1;
            state    <= FULL;
        end else if (state == FULL && out_ready) begin
            state    <= EMPTY;
        end
    end

endmodule

// File: tb/tb_reg_arbiter.sv
// Randomized self-checking bench for reg_arbiter against a cycle-level
// reference model; works with or without REG_ARBITER_BACK2BACK_EN.
module tb_reg_arbiter;

    localparam int X = 32;
    localparam int W = X + 1;
`ifdef REG_ARBITER_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req;
    logic [4*W-1:0] req_data;
    logic [3:0]     gnt;
    logic [X:0]     out_data;
    logic [1:0]     out_src;
    logic           out_valid;
    logic           out_ready;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_full;
    int         m_ptr;
    logic [X:0] m_data;
    int         m_src;

    // DUT observations from the most recent step
    logic [X:0] s_data;
    logic [1:0] s_src;
    logic       s_valid;
    int         gq[$];

    always #5 clk = ~clk;

    reg_arbiter #(.X(X)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*W-1:0] rnd_data();
        logic [4*W-1:0] d;
        for (int i = 0; i < 4; i++)
            d[i*W +: W] = {1'($urandom), 32'($urandom)};
        return d;
    endfunction

    // One cycle: drive, check outputs against the model, then advance the model
    task automatic step(input logic rst, input logic [3:0] r, input logic [4*W-1:0] d,
                        input logic rdy);
        int         win;
        bit         take;
        logic [3:0] exp_gnt;
        logic [X:0] pay;
        @(negedge clk);
        rst_n     = rst;
        req       = r;
        req_data  = d;
        out_ready = rdy;
        #1;
        win = -1;
        for (int k = 0; k < 4; k++)
            if (win < 0 && r[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        take    = rst && (win >= 0) && (!m_full || (B2B && rdy));
        exp_gnt = take ? 4'(1 << win) : 4'h0;
        check_eq("gnt", 64'(gnt), 64'(exp_gnt));
        check_eq("out_valid", 64'(out_valid), 64'(m_full));
        check_eq("out_data", 64'(out_data), 64'(m_data));
        check_eq("out_src", 64'(out_src), 64'(m_src));
        s_data  = out_data;
        s_src   = out_src;
        s_valid = out_valid;
        for (int i = 0; i < 4; i++)
            if (gnt[i]) gq.push_back(i);
        if (!rst) begin
            m_full = 1'b0;
            m_ptr  = 0;
            m_data = '0;
            m_src  = 0;
        end else if (take) begin
            pay    = d[win*W +: W];
            m_data = pay;
            m_src  = win;
            m_ptr  = (win + 1) % 4;
            m_full = 1'b1;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic drain();
        repeat (3) step(1'b1, 4'h0, rnd_data(), 1'b1);
    endtask

    initial begin
        logic [4*W-1:0] d;
        rst_n = 1'b0; req = 4'hF; req_data = '0; out_ready = 1'b0;
        m_full = 1'b0; m_ptr = 0; m_data = '0; m_src = 0;
        @(posedge clk);

        // reset with all requests pending
        repeat (2) step(1'b0, 4'hF, rnd_data(), 1'b0);
        check_eq("rst_valid", 64'(s_valid), 64'd0);
        check_eq("rst_data", 64'(s_data), 64'd0);

        // fairness from ptr 0
        gq.delete();
        repeat (10) step(1'b1, 4'hF, rnd_data(), 1'b1);
        check_eq("fair_count_ge5", 64'(gq.size() >= 5), 64'd1);
        if (gq.size() >= 5) begin
            check_eq("fair0", 64'(gq[0]), 64'd0);
            check_eq("fair1", 64'(gq[1]), 64'd1);
            check_eq("fair2", 64'(gq[2]), 64'd2);
            check_eq("fair3", 64'(gq[3]), 64'd3);
            check_eq("fair4", 64'(gq[4]), 64'd0);
        end
        drain();

        // single requester 2
        d = rnd_data();
        d[2*W +: W] = 33'h1_DEADBEEF;
        gq.delete();
        step(1'b1, 4'b0100, d, 1'b0);
        step(1'b1, 4'b0000, rnd_data(), 1'b0);
        check_eq("single_gnt", 64'(gq.size() == 1 && gq[0] == 2), 64'd1);
        check_eq("single_data", 64'(s_data), 64'h1_DEADBEEF);
        check_eq("single_src", 64'(s_src), 64'd2);
        check_eq("single_valid", 64'(s_valid), 64'd1);

        // backpressure, then requester 1 released
        gq.delete();
        repeat (5) step(1'b1, 4'b0010, rnd_data(), 1'b0);
        check_eq("bp_nognt", 64'(gq.size()), 64'd0);
        check_eq("bp_data", 64'(s_data), 64'h1_DEADBEEF);
        step(1'b1, 4'b0010, rnd_data(), 1'b1);
        if (!B2B) step(1'b1, 4'b0010, rnd_data(), 1'b1);
        check_eq("bp_grant1", 64'(gq.size() == 1 && gq[0] == 1), 64'd1);
        drain();

        // wrap: grant 2 sets ptr to 3, then 3 before 0
        step(1'b1, 4'b0100, rnd_data(), 1'b1);
        drain();
        gq.delete();
        repeat (6) step(1'b1, (gq.size() == 0) ? 4'b1001 : 4'b0001, rnd_data(), 1'b1);
        check_eq("wrap_order", 64'(gq.size() >= 2 && gq[0] == 3 && gq[1] == 0), 64'd1);
        drain();

        // reset while FULL with out_src 1
        step(1'b1, 4'b0010, rnd_data(), 1'b0);
        step(1'b0, 4'b0000, rnd_data(), 1'b0);
        gq.delete();
        step(1'b1, 4'b0011, rnd_data(), 1'b0);
        check_eq("rstmid_valid", 64'(s_valid), 64'd0);
        check_eq("rstmid_grant0", 64'(gq.size() == 1 && gq[0] == 0), 64'd1);
        drain();

        // random traffic
        for (int n = 0; n < 400; n++)
            step(($urandom_range(0, 31) != 0), 4'($urandom), rnd_data(),
                 1'($urandom_range(0, 2) != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
